// File: rtl/config_chain_loader_if.sv
// Bus bundle for config_chain_loader: shift/commit controls from the configurator
// and the committed config, chain and status back from the loader.
interface config_chain_loader_if #(
  parameter int CHAIN_LEN = 64,
  parameter int LANES     = 4
);
  localparam int CW = $clog2(CHAIN_LEN + 1);

  logic                       cen;
  logic [LANES-1:0]           shift_in;
  logic [LANES-1:0]           set_in;
  logic                       err_clr;
  logic [LANES*CHAIN_LEN-1:0] config_out;
  logic [LANES-1:0]           chain_out;
  logic [CW-1:0]              bit_count;
  logic [LANES-1:0]           lane_valid;
  logic                       count_err;

  modport master (
    output cen, shift_in, set_in, err_clr,
    input  config_out, chain_out, bit_count, lane_valid, count_err
  );

  modport slave (
    input  cen, shift_in, set_in, err_clr,
    output config_out, chain_out, bit_count, lane_valid, count_err
  );
endinterface

// File: rtl/config_chain_loader.sv
// Multi-lane serial config loader: per-lane shadow shift registers committed into
// directly-registered config words, with a saturating bit counter and sticky count check.
module config_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int LANES     = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  config_chain_loader_if.slave bus
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] FULL = CW'(CHAIN_LEN);

  logic [LANES-1:0][CHAIN_LEN-1:0] shadow;
  logic [LANES-1:0][CHAIN_LEN-1:0] committed;
  logic [LANES-1:0]                chain_q;
  logic [LANES-1:0]                valid_q;
  logic [CW-1:0]                   count_q;
  logic                            err_q;
  logic                            any_set;

  assign any_set = |bus.set_in;

  // Commit samples the pre-edge shadow, so a same-edge shift never leaks into it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      shadow    <= '0;
      committed <= '0;
      chain_q   <= '0;
      valid_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        chain_q[i] <= shadow[i][0];
        if (bus.set_in[i]) begin
          committed[i] <= shadow[i];
          valid_q[i]   <= 1'b1;
        end
        if (bus.cen)
          shadow[i] <= {bus.shift_in[i], shadow[i][CHAIN_LEN-1:1]};
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      count_q <= '0;
    end else if (any_set) begin
      count_q <= bus.cen ? CW'(1) : '0;
    end else if (bus.cen && count_q != FULL) begin
      count_q <= count_q + CW'(1);
    end
  end

  // A count-error commit outranks a same-edge clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      err_q <= 1'b0;
    else if (any_set && count_q != FULL)
      err_q <= 1'b1;
    else if (bus.err_clr)
      err_q <= 1'b0;
  end

  assign bus.config_out = committed;
  assign bus.chain_out  = chain_q;
  assign bus.bit_count  = count_q;
  assign bus.lane_valid = valid_q;
  assign bus.count_err  = err_q;
endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: expectations queued with each stimulus step
// and checked after the following clock edge.
module tb_config_chain_loader;
  localparam int CL = 64;
  localparam int LN = 4;
  localparam int W  = CL * LN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  config_chain_loader_if #(.CHAIN_LEN(CL), .LANES(LN)) bus ();
  config_chain_loader #(.CHAIN_LEN(CL), .LANES(LN)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  typedef struct {
    int          kind;
    string       tag;
    logic [W-1:0] val;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  logic [CL-1:0] exp_cfg [LN];

  // kind: 0 config_out, 1 chain_out, 2 bit_count, 3 lane_valid, 4 count_err, 5 chain_out[0]
  function automatic logic [W-1:0] observe(int kind);
    case (kind)
      0:       return bus.config_out;
      1:       return W'(bus.chain_out);
      2:       return W'(bus.bit_count);
      3:       return W'(bus.lane_valid);
      4:       return W'(bus.count_err);
      default: return W'(bus.chain_out[0]);
    endcase
  endfunction

  task automatic expect_val(input int kind, input string tag, input logic [W-1:0] v);
    exp_t e;
    e.kind = kind;
    e.tag  = tag;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic expect_cfg(input string tag);
    logic [W-1:0] v;
    for (int i = 0; i < LN; i++) v[i*CL +: CL] = exp_cfg[i];
    expect_val(0, tag, v);
  endtask

  task automatic drain();
    exp_t e;
    logic [W-1:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.kind);
      n_vec++;
      assert (o === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick(input logic c, input logic [LN-1:0] sh, input logic [LN-1:0] st,
                      input logic clr);
    @(negedge clk);
    bus.cen      = c;
    bus.shift_in = sh;
    bus.set_in   = st;
    bus.err_clr  = clr;
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic expect_idle_zero(input string tag);
    for (int i = 0; i < LN; i++) exp_cfg[i] = '0;
    expect_cfg({tag, "_cfg"});
    expect_val(1, {tag, "_chain"}, '0);
    expect_val(2, {tag, "_cnt"}, '0);
    expect_val(3, {tag, "_valid"}, '0);
    expect_val(4, {tag, "_err"}, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] k, q, r;
    logic [63:0] p [LN];
    logic [69:0] s;
    logic [LN-1:0] sh;

    k = 64'hDEADBEEF_CAFEF00D;
    q = 64'hA5A55A5A_C3C33C3C;
    r = 64'h0F1E2D3C_4B5A6978;
    p[0] = 64'h01234567_89ABCDEF;
    p[1] = 64'hF0E1D2C3_B4A59687;
    p[2] = 64'h5A5A3C3C_0FF09669;
    p[3] = 64'h80000000_00000001;
    s = {6'b110010, 64'hF0F01234_56789A2D};

    rst = 1'b1;
    bus.cen = 1'b0; bus.shift_in = '0; bus.set_in = '0; bus.err_clr = 1'b0;
    #12;
    expect_idle_zero("reset");
    drain();
    @(negedge clk);
    rst = 1'b0;

    // Full 64-bit load on lane 0, then commit
    for (int j = 0; j < CL; j++) tick(1'b1, {3'b000, k[j]}, '0, 1'b0);
    expect_val(2, "t1_cnt_full", W'(64));
    drain();
    exp_cfg[0] = k;
    expect_cfg("t1_cfg");
    expect_val(3, "t1_valid", W'(4'b0001));
    expect_val(4, "t1_err", '0);
    expect_val(2, "t1_cnt_after", '0);
    tick(1'b0, '0, 4'b0001, 1'b0);

    // Short load (63 bits) on all lanes, commit all -> count error, then clear
    for (int j = 0; j < CL - 1; j++) begin
      for (int i = 0; i < LN; i++) sh[i] = p[i][j];
      tick(1'b1, sh, '0, 1'b0);
    end
    expect_val(2, "t2_cnt63", W'(63));
    drain();
    exp_cfg[0] = {p[0][62:0], k[63]};
    for (int i = 1; i < LN; i++) exp_cfg[i] = {p[i][62:0], 1'b0};
    expect_cfg("t2_cfg");
    expect_val(3, "t2_valid", W'(4'b1111));
    expect_val(4, "t2_err_set", W'(1));
    expect_val(2, "t2_cnt_after", '0);
    tick(1'b0, '0, 4'b1111, 1'b0);
    expect_val(4, "t2_err_clr", '0);
    tick(1'b0, '0, '0, 1'b1);

    // Overshift 70 bits: count saturates, chain_out[0] replays the stream head
    for (int j = 0; j < 70; j++) begin
      if (j >= 62) expect_val(2, $sformatf("t3_cnt_%0d", j + 1), W'((j + 1 > CL) ? CL : j + 1));
      if (j >= 64) expect_val(5, $sformatf("t3_chain_%0d", j + 1), W'(s[j-64]));
      tick(1'b1, {3'b000, s[j]}, '0, 1'b0);
    end
    exp_cfg[0] = s[69:6];
    expect_cfg("t3_cfg");
    expect_val(4, "t3_err", '0);
    expect_val(2, "t3_cnt_after", '0);
    tick(1'b0, '0, 4'b0001, 1'b0);

    // Shift and commit on the same edge: commit takes the pre-shift shadow
    for (int j = 0; j < CL; j++) tick(1'b1, {2'b00, q[j], 1'b0}, '0, 1'b0);
    exp_cfg[1] = q;
    expect_cfg("t4_cfg");
    expect_val(2, "t4_cnt_one", W'(1));
    expect_val(4, "t4_err", '0);
    tick(1'b1, 4'b0010, 4'b0010, 1'b0);

    // Clear and count-error commit on the same edge: set wins
    exp_cfg[2] = '0;
    expect_cfg("t5_cfg");
    expect_val(4, "t5_err_wins", W'(1));
    expect_val(3, "t5_valid", W'(4'b1111));
    tick(1'b0, '0, 4'b0100, 1'b1);
    expect_val(4, "t5_err_clr", '0);
    tick(1'b0, '0, '0, 1'b1);

    // Held commit: second consecutive commit is a count error
    for (int j = 0; j < CL; j++) tick(1'b1, {r[j], 3'b000}, '0, 1'b0);
    exp_cfg[3] = r;
    expect_cfg("t6_cfg1");
    expect_val(4, "t6_err_first", '0);
    expect_val(2, "t6_cnt_first", '0);
    tick(1'b0, '0, 4'b1000, 1'b0);
    expect_cfg("t6_cfg2");
    expect_val(4, "t6_err_second", W'(1));
    tick(1'b0, '0, 4'b1000, 1'b0);
    expect_val(4, "t6_err_clr", '0);
    tick(1'b0, '0, '0, 1'b1);

    // Asynchronous reset mid-shift, then a clean reload
    for (int j = 0; j < 30; j++) tick(1'b1, {3'b000, k[j]}, '0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    expect_idle_zero("t7_async");
    drain();
    rst = 1'b0;
    expect_val(2, "t7_first_edge", W'(1));
    for (int j = 0; j < CL; j++) tick(1'b1, {3'b000, k[j]}, '0, 1'b0);
    exp_cfg[0] = k;
    expect_cfg("t7_cfg");
    expect_val(3, "t7_valid", W'(4'b0001));
    expect_val(4, "t7_err", '0);
    tick(1'b0, '0, 4'b0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
